alu_ctrl_seq: RTL

- Parametrised, handshaked successor to the combinational ALU-control decoder in the impostor_32 execute stage.
- Decodes alu_op/funct into the 4-bit ALU code, memory-size code and branch-compare code, then registers the result behind a valid/ready stage.
- Adds RV32M mul/div support: M-ext ops hold the stage for a configurable latency before output. Also adds illegal-op flagging and a pipeline flush.

---
 rtl/alu_ctrl_seq_if.sv | 15 +
 rtl/alu_ctrl_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode request / registered result handshake bundle
interface alu_ctrl_seq_if;
   logic       in_valid, in_ready, f7b5, out_valid, out_ready, md_start, illegal;
   logic [2:0] alu_op, funct3, mem, md_op;
   logic [3:0] alu_ctrl;
   logic [1:0] equal_comp;
   modport master (
      output in_valid, alu_op, funct3, f7b5, out_ready,
      input  in_ready, out_valid, alu_ctrl, mem, equal_comp, md_op, md_start, illegal
   );
   modport slave (
      input  in_valid, alu_op, funct3, f7b5, out_ready,
      output in_ready, out_valid, alu_ctrl, mem, equal_comp, md_op, md_start, illegal
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: handshaked ALU-control decoder with RV32M latency hold
module alu_ctrl_seq #(
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 32,
   parameter bit ENABLE_M = 1'b1,
   parameter int CNT_W    = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   alu_ctrl_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HOLD, MD_WAIT} state_t;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       alu_q, alu_d, ar_code, dec_alu;
   logic [2:0]       mem_q, mem_d, md_q, md_d, dec_mem, dec_md;
   logic [1:0]       eq_q, eq_d, dec_eq;
   logic             ill_q, ill_d, dec_ill, ar_ok, ar_b5, is_m, rdy, accept, retire;
   // I-type only honours funct7[5] for shifts; slli with it set must decode illegal
   assign ar_b5 = (bus.alu_op[0] && bus.funct3 != 3'b101 && bus.funct3 != 3'b001) ? 1'b0 : bus.f7b5;
   always_comb begin
      ar_code = 4'b0010;
      ar_ok   = 1'b1;
      case ({bus.funct3, ar_b5})
         4'b0000: ar_code = 4'b0010;
         4'b0001: ar_code = 4'b0110;
         4'b0010: ar_code = 4'b0100;
         4'b0100: ar_code = 4'b0101;
         4'b0110: ar_code = 4'b0111;
         4'b1000: ar_code = 4'b0011;
         4'b1010: ar_code = 4'b1000;
         4'b1011: ar_code = 4'b1001;
         4'b1100: ar_code = 4'b0001;
         4'b1110: ar_code = 4'b0000;
         default: ar_ok   = 1'b0;
      endcase
   end
   always_comb begin
      dec_alu = 4'b0010;
      dec_mem = 3'b000;
      dec_eq  = 2'b00;
      dec_md  = 3'b000;
      dec_ill = 1'b0;
      case (bus.alu_op)
         3'b000, 3'b001: begin
            dec_alu = ar_code;
            dec_ill = !ar_ok;
         end
         3'b010:
            case (bus.funct3)
               3'b000:  dec_mem = 3'b001;
               3'b001:  dec_mem = 3'b010;
               3'b010:  dec_mem = 3'b011;
               3'b100:  dec_mem = 3'b101;
               3'b101:  dec_mem = 3'b100;
               default: dec_ill = 1'b1;
            endcase
         3'b100:
            case (bus.funct3)
               3'b000:         dec_mem = 3'b110;
               3'b001, 3'b010: dec_mem = 3'b111;
               default:        dec_ill = 1'b1;
            endcase
         3'b011: begin
            dec_alu = bus.funct3[2] ? (bus.funct3[1] ? 4'b0111 : 4'b0101) : 4'b0011;
            dec_eq  = (bus.funct3[0] ^ !bus.funct3[2]) ? 2'b11 : 2'b10;
            dec_ill = bus.funct3[2:1] == 2'b01;
         end
         3'b101: begin
            dec_alu = 4'b1111;
            dec_md  = bus.funct3;
            dec_ill = !ENABLE_M;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_alu = 4'b0010;
         dec_mem = 3'b000;
         dec_eq  = 2'b00;
         dec_md  = 3'b000;
      end
   end
   assign is_m   = bus.alu_op == 3'b101 && !dec_ill;
   assign rdy    = !flush && (state_q == IDLE || (state_q == HOLD && bus.out_ready));
   assign accept = bus.in_valid && rdy;
   assign retire = state_q == HOLD && bus.out_ready;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      eq_d    = eq_q;
      md_d    = md_q;
      ill_d   = ill_q;
      if (flush) state_d = IDLE;
      else if (accept) begin
         state_d = is_m ? MD_WAIT : HOLD;
         cnt_d   = is_m ? (bus.funct3[2] ? DIV_CNT : MUL_CNT) : '0;
         alu_d   = dec_alu;
         mem_d   = dec_mem;
         eq_d    = dec_eq;
         md_d    = dec_md;
         ill_d   = dec_ill;
      end else if (retire) state_d = IDLE;
      else if (state_q == MD_WAIT) begin
         state_d = cnt_q == '0 ? HOLD : MD_WAIT;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         alu_q   <= 4'b0010;
         mem_q   <= 3'b000;
         eq_q    <= 2'b00;
         md_q    <= 3'b000;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         eq_q    <= eq_d;
         md_q    <= md_d;
         ill_q   <= ill_d;
      end
   end
   assign bus.in_ready   = rdy;
   assign bus.out_valid  = state_q == HOLD;
   assign bus.alu_ctrl   = alu_q;
   assign bus.mem        = mem_q;
   assign bus.equal_comp = eq_q;
   assign bus.md_op      = md_q;
   assign bus.illegal    = ill_q;
   assign bus.md_start   = accept && is_m;
endmodule
